// File: rtl/dma_cfg_slave_mc_if.sv
// AXI slave bus bundle for the multi-channel DMA configuration register file.
interface dma_cfg_slave_mc_if #(
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
);
    logic                   S_AWValid, S_AWReady;
    logic [ID_BITS-1:0]     S_AWID;
    logic [ADDR_BITS-1:0]   S_AWAddr;
    logic [LEN_BITS-1:0]    S_AWLen;
    logic [1:0]             S_AWBurst;
    logic                   S_WValid, S_WReady, S_WLast;
    logic [DATA_BITS-1:0]   S_WData;
    logic [DATA_BITS/8-1:0] S_WStrb;
    logic                   S_BValid, S_BReady;
    logic [ID_BITS-1:0]     S_BID;
    logic [1:0]             S_BResp;
    logic                   S_ARValid, S_ARReady;
    logic [ID_BITS-1:0]     S_ARID;
    logic [ADDR_BITS-1:0]   S_ARAddr;
    logic [LEN_BITS-1:0]    S_ARLen;
    logic [1:0]             S_ARBurst;
    logic                   S_RValid, S_RReady, S_RLast;
    logic [ID_BITS-1:0]     S_RID;
    logic [DATA_BITS-1:0]   S_RData;
    logic [1:0]             S_RResp;

    modport slave (
        input  S_AWValid, S_AWID, S_AWAddr, S_AWLen, S_AWBurst, output S_AWReady,
        input  S_WValid, S_WData, S_WStrb, S_WLast, output S_WReady,
        output S_BValid, S_BID, S_BResp, input S_BReady,
        input  S_ARValid, S_ARID, S_ARAddr, S_ARLen, S_ARBurst, output S_ARReady,
        output S_RValid, S_RID, S_RData, S_RResp, S_RLast, input S_RReady
    );
    modport master (
        output S_AWValid, S_AWID, S_AWAddr, S_AWLen, S_AWBurst, input S_AWReady,
        output S_WValid, S_WData, S_WStrb, S_WLast, input S_WReady,
        input  S_BValid, S_BID, S_BResp, output S_BReady,
        output S_ARValid, S_ARID, S_ARAddr, S_ARLen, S_ARBurst, input S_ARReady,
        input  S_RValid, S_RID, S_RData, S_RResp, S_RLast, output S_RReady
    );
endinterface

// File: rtl/dma_cfg_slave_mc.sv
// AXI register file configuring NUM_CH DMA channels (CTRL/SRC/DST/LEN/STATUS each).
// Define DMA_CFG_IRQ_EN to enable the CTRL.IE bit and the registered IRQ output.
module dma_cfg_slave_mc #(
    parameter int NUM_CH    = 2,
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    dma_cfg_slave_mc_if.slave           s,
    output logic [NUM_CH-1:0]           DMAEN,
    output logic [NUM_CH*DATA_BITS-1:0] DMASRC,
    output logic [NUM_CH*DATA_BITS-1:0] DMADST,
    output logic [NUM_CH*DATA_BITS-1:0] DMALEN,
    input  logic [NUM_CH-1:0]           DMADONE,
    output logic                        IRQ
);
    localparam logic [7:0] OFF_CTRL = 8'h00, OFF_SRC = 8'h04, OFF_DST = 8'h08,
                           OFF_LEN  = 8'h0C, OFF_STAT = 8'h10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
    state_t state, state_nx;

    logic [ID_BITS-1:0]  id_q;
    logic [15:0]         addr_q, addr_nx;
    logic [LEN_BITS-1:0] blen_q, cnt;
    logic                fixed_q, err_q;
    logic [3:0]          ch_sel;
    logic [7:0]          off;
    logic                mapped, aw_hs, ar_hs, w_hs, r_hs, r_last, wr_en;
    logic [DATA_BITS-1:0] rd_ch [16];
`ifdef DMA_CFG_IRQ_EN
    logic [NUM_CH-1:0]   done_v, ie_v;
`endif
    logic                unused_ok;

    function automatic logic [DATA_BITS-1:0] merge(input logic [DATA_BITS-1:0] old,
                                                   input logic [DATA_BITS-1:0] wd,
                                                   input logic [DATA_BITS/8-1:0] st);
        merge = old;
        for (int b = 0; b < DATA_BITS/8; b++)
            if (st[b]) merge[8*b +: 8] = wd[8*b +: 8];
    endfunction

    // Decode always works on the captured beat address; bits [15:12] alias.
    assign ch_sel  = addr_q[11:8];
    assign off     = addr_q[7:0];
    assign mapped  = ({1'b0, ch_sel} < 5'(NUM_CH)) &&
                     (off inside {OFF_CTRL, OFF_SRC, OFF_DST, OFF_LEN, OFF_STAT});
    assign addr_nx = fixed_q ? addr_q : addr_q + 16'd4;
    assign r_last  = (cnt == blen_q);

    assign aw_hs = (state == IDLE)  && s.S_AWValid;
    assign ar_hs = (state == IDLE)  && !s.S_AWValid && s.S_ARValid;
    assign w_hs  = (state == WDATA) && s.S_WValid;
    assign r_hs  = (state == RDATA) && s.S_RReady;
    assign wr_en = w_hs && mapped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        s.S_AWReady = 1'b0;
        s.S_ARReady = 1'b0;
        s.S_WReady  = 1'b0;
        s.S_BValid  = 1'b0;
        s.S_RValid  = 1'b0;
        case (state)
            IDLE: begin
                s.S_AWReady = 1'b1;
                s.S_ARReady = !s.S_AWValid;
                if (s.S_AWValid)      state_nx = WDATA;
                else if (s.S_ARValid) state_nx = RDATA;
            end
            WDATA: begin
                s.S_WReady = 1'b1;
                if (s.S_WValid && s.S_WLast) state_nx = WRESP;
            end
            WRESP: begin
                s.S_BValid = 1'b1;
                if (s.S_BReady) state_nx = IDLE;
            end
            RDATA: begin
                s.S_RValid = 1'b1;
                if (s.S_RReady && r_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            blen_q  <= '0;
            cnt     <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE) err_q <= 1'b0;
            if (aw_hs) begin
                id_q    <= s.S_AWID;
                addr_q  <= s.S_AWAddr[15:0];
                fixed_q <= (s.S_AWBurst == 2'b00);
            end else if (ar_hs) begin
                id_q    <= s.S_ARID;
                addr_q  <= s.S_ARAddr[15:0];
                blen_q  <= s.S_ARLen;
                fixed_q <= (s.S_ARBurst == 2'b00);
                cnt     <= '0;
            end
            if (w_hs) begin
                addr_q <= addr_nx;
                if (!mapped) err_q <= 1'b1;
            end
            if (r_hs) begin
                addr_q <= addr_nx;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < 16; c++) begin : g_ch
        if (c < NUM_CH) begin : g_live
            logic                 sel, en_q, ie_q, done_q;
            logic [DATA_BITS-1:0] src_q, dst_q, len_r;
            assign sel = wr_en && (ch_sel == 4'(c));

            // DMADONE beats a same-cycle EN set and a same-cycle DONE clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_q   <= 1'b0;
                    done_q <= 1'b0;
                    src_q  <= '0;
                    dst_q  <= '0;
                    len_r  <= '0;
                end else begin
                    if (sel && off == OFF_SRC) src_q <= merge(src_q, s.S_WData, s.S_WStrb);
                    if (sel && off == OFF_DST) dst_q <= merge(dst_q, s.S_WData, s.S_WStrb);
                    if (sel && off == OFF_LEN) len_r <= merge(len_r, s.S_WData, s.S_WStrb);
                    if (DMADONE[c])
                        en_q <= 1'b0;
                    else if (sel && off == OFF_CTRL && s.S_WStrb[0])
                        en_q <= s.S_WData[0];
                    if (DMADONE[c])
                        done_q <= 1'b1;
                    else if (sel && off == OFF_STAT && s.S_WStrb[0] && s.S_WData[0])
                        done_q <= 1'b0;
                end
            end
`ifdef DMA_CFG_IRQ_EN
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                                          ie_q <= 1'b0;
                else if (sel && off == OFF_CTRL && s.S_WStrb[0])  ie_q <= s.S_WData[1];
            end
            assign done_v[c] = done_q;
            assign ie_v[c]   = ie_q;
`else
            assign ie_q = 1'b0;
`endif
            assign rd_ch[c] = (off == OFF_CTRL) ? {{(DATA_BITS-2){1'b0}}, ie_q, en_q} :
                              (off == OFF_SRC)  ? src_q :
                              (off == OFF_DST)  ? dst_q :
                              (off == OFF_LEN)  ? len_r :
                              (off == OFF_STAT) ? {{(DATA_BITS-2){1'b0}}, en_q, done_q} : '0;
            assign DMAEN[c]                         = en_q;
            assign DMASRC[c*DATA_BITS +: DATA_BITS] = src_q;
            assign DMADST[c*DATA_BITS +: DATA_BITS] = dst_q;
            assign DMALEN[c*DATA_BITS +: DATA_BITS] = len_r;
        end else begin : g_none
            assign rd_ch[c] = '0;
        end
    end

`ifdef DMA_CFG_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) IRQ <= 1'b0;
        else     IRQ <= |(done_v & ie_v);
    end
`else
    assign IRQ = 1'b0;
`endif

    assign s.S_BID   = id_q;
    assign s.S_BResp = (state == WRESP && err_q) ? 2'b10 : 2'b00;
    assign s.S_RID   = id_q;
    assign s.S_RData = (state == RDATA && mapped) ? rd_ch[ch_sel] : '0;
    assign s.S_RResp = (state == RDATA && !mapped) ? 2'b10 : 2'b00;
    assign s.S_RLast = (state == RDATA) && r_last;

    // Write length comes from WLast; upper address bits are outside the decode window.
    assign unused_ok = ^{s.S_AWLen, s.S_AWAddr[ADDR_BITS-1:16], s.S_ARAddr[ADDR_BITS-1:16],
                         addr_q[15:12]};
endmodule

// File: tb/tb_dma_cfg_slave_mc.sv
// Scoreboard bench for dma_cfg_slave_mc: stimulus pushes expected B/R beats, a monitor pops them.
module tb_dma_cfg_slave_mc;
    localparam int NC = 2;
`ifdef DMA_CFG_IRQ_EN
    localparam logic        IRQ_ON = 1'b1;
    localparam logic [31:0] IE_RB  = 32'h2;
`else
    localparam logic        IRQ_ON = 1'b0;
    localparam logic [31:0] IE_RB  = 32'h0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    dma_cfg_slave_mc_if #(.ID_BITS(8), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4)) bus ();
    logic [NC-1:0]    dmaen, dmadone;
    logic [NC*32-1:0] dmasrc, dmadst, dmalen;
    logic             irq;

    dma_cfg_slave_mc #(.NUM_CH(NC), .ID_BITS(8), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4)) dut (
        .clk(clk), .rst(rst), .s(bus.slave), .DMAEN(dmaen), .DMASRC(dmasrc),
        .DMADST(dmadst), .DMALEN(dmalen), .DMADONE(dmadone), .IRQ(irq));

    typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];
    int n_chk = 0, n_fail = 0;
    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    logic [1:0]  done_mask = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every B or R handshake is matched against the head of its queue.
    always @(negedge clk) begin : mon
        b_exp_t be;
        r_exp_t re;
        if (!rst) begin
            if (bus.S_BValid && bus.S_BReady) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    be = bq.pop_front();
                    chk("bresp", 64'(bus.S_BResp), 64'(be.resp));
                    chk("bid", 64'(bus.S_BID), 64'(be.id));
                end
            end
            if (bus.S_RValid && bus.S_RReady) begin
                if (rq.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    re = rq.pop_front();
                    chk("rdata", 64'(bus.S_RData), 64'(re.data));
                    chk("rresp", 64'(bus.S_RResp), 64'(re.resp));
                    chk("rlast", 64'(bus.S_RLast), 64'(re.last));
                    chk("rid", 64'(bus.S_RID), 64'(re.id));
                end
            end
        end
    end

    // 0 AW, 1 W, 2 B, 3 AR, 4 R; returns 1ns after the handshake edge.
    task automatic wait_hs(input int which);
        logic ok;
        int   t;
        t = 0;
        do begin
            @(negedge clk);
            case (which)
                0: ok = bus.S_AWReady;
                1: ok = bus.S_WReady;
                2: ok = bus.S_BValid;
                3: ok = bus.S_ARReady;
                default: ok = bus.S_RValid;
            endcase
            @(posedge clk);
            t++;
        end while (!ok && t < 50);
        if (!ok) chk($sformatf("timeout_ch%0d", which), 1, 0);
        #1;
    endtask

    task automatic axi_wr(input logic [15:0] a, input int n, input logic [1:0] burst,
                          input logic [7:0] id, input logic [1:0] resp);
        bq.push_back('{id: id, resp: resp});
        bus.S_AWValid = 1'b1; bus.S_AWAddr = {16'h0, a}; bus.S_AWLen = 4'(n - 1);
        bus.S_AWBurst = burst; bus.S_AWID = id;
        wait_hs(0);
        bus.S_AWValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.S_WValid = 1'b1; bus.S_WData = wd[i]; bus.S_WStrb = ws[i];
            bus.S_WLast = (i == n - 1); dmadone = done_mask;
            wait_hs(1);
            dmadone = '0;
        end
        bus.S_WValid = 1'b0; bus.S_WLast = 1'b0;
        wait_hs(2);
    endtask

    task automatic exp_r(input logic [7:0] id, input logic [31:0] d, input logic [1:0] resp,
                         input logic last);
        rq.push_back('{id: id, data: d, resp: resp, last: last});
    endtask

    task automatic axi_rd(input logic [15:0] a, input int n, input logic [1:0] burst,
                          input logic [7:0] id);
        bus.S_ARValid = 1'b1; bus.S_ARAddr = {16'h0, a}; bus.S_ARLen = 4'(n - 1);
        bus.S_ARBurst = burst; bus.S_ARID = id;
        wait_hs(3);
        bus.S_ARValid = 1'b0;
        for (int i = 0; i < n; i++) wait_hs(4);
    endtask

    task automatic rd1(input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp);
        exp_r(8'h3C, d, resp, 1'b1);
        axi_rd(a, 1, 2'b01, 8'h3C);
    endtask

    initial begin
        bus.S_AWValid = 0; bus.S_AWID = 0; bus.S_AWAddr = 0; bus.S_AWLen = 0; bus.S_AWBurst = 0;
        bus.S_WValid = 0; bus.S_WData = 0; bus.S_WStrb = 0; bus.S_WLast = 0; bus.S_BReady = 1;
        bus.S_ARValid = 0; bus.S_ARID = 0; bus.S_ARAddr = 0; bus.S_ARLen = 0; bus.S_ARBurst = 0;
        bus.S_RReady = 1; dmadone = '0;
        for (int i = 0; i < 8; i++) begin wd[i] = '0; ws[i] = 4'hF; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 64'(bus.S_AWReady), 1);
        chk("rst_arready", 64'(bus.S_ARReady), 1);
        chk("rst_valids", 64'({bus.S_WReady, bus.S_BValid, bus.S_RValid}), 0);
        chk("rst_regs", 64'({dmaen, irq}), 0);
        chk("rst_src", dmasrc, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single write / read-back on channel 1
        wd[0] = 32'h8000_0000;
        axi_wr(16'h0104, 1, 2'b01, 8'h05, 2'b00);
        chk("ch1_src", 64'(dmasrc[63:32]), 64'h8000_0000);
        rd1(16'h0104, 32'h8000_0000, 2'b00);

        // INCR burst across SRC/DST/LEN/STATUS, then read back as a burst
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        axi_wr(16'h0004, 4, 2'b01, 8'h11, 2'b00);
        chk("burst_regs", {dmasrc[31:0], dmadst[31:0]}, {32'h1, 32'h2});
        chk("burst_len", 64'(dmalen[31:0]), 64'h3);
        exp_r(8'h22, 32'h1, 2'b00, 1'b0);
        exp_r(8'h22, 32'h2, 2'b00, 1'b0);
        exp_r(8'h22, 32'h3, 2'b00, 1'b0);
        exp_r(8'h22, 32'h0, 2'b00, 1'b1);
        axi_rd(16'h0004, 4, 2'b01, 8'h22);
        // FIXED read burst holds the address
        exp_r(8'h23, 32'h8000_0000, 2'b00, 1'b0);
        exp_r(8'h23, 32'h8000_0000, 2'b00, 1'b1);
        axi_rd(16'h0104, 2, 2'b00, 8'h23);

        // byte strobes
        wd[0] = 32'h1234_5678;
        axi_wr(16'h0008, 1, 2'b01, 8'h01, 2'b00);
        wd[0] = 32'h0000_00AA; ws[0] = 4'h1;
        axi_wr(16'h0008, 1, 2'b01, 8'h02, 2'b00);
        ws[0] = 4'hF;
        rd1(16'h0008, 32'h1234_56AA, 2'b00);

        // unmapped accesses
        wd[0] = 32'hDEAD_BEEF;
        axi_wr(16'h0200, 1, 2'b01, 8'h09, 2'b10);
        chk("slverr_src", dmasrc, {32'h8000_0000, 32'h1});
        chk("slverr_dst", dmadst, {32'h0, 32'h1234_56AA});
        rd1(16'h0014, 32'h0, 2'b10);
        rd1(16'h0101, 32'h0, 2'b10);
        // error is sticky across a burst whose second beat is unmapped
        wd[0] = 32'h0; wd[1] = 32'h0;
        axi_wr(16'h0010, 2, 2'b01, 8'h0A, 2'b10);
        chk("sticky_len", dmalen, {32'h0, 32'h3});

        // enable, done pulse, IRQ, W1C
        wd[0] = 32'h3;
        axi_wr(16'h0000, 1, 2'b01, 8'h0B, 2'b00);
        chk("en_set", 64'(dmaen), 64'h1);
        dmadone = 2'b01;
        @(posedge clk); #1;
        dmadone = '0;
        chk("en_cleared", 64'(dmaen), 0);
        chk("irq_not_yet", 64'(irq), 0);
        @(posedge clk); #1;
        chk("irq_set", 64'(irq), 64'(IRQ_ON));
        rd1(16'h0010, 32'h1, 2'b00);
        rd1(16'h0000, IE_RB, 2'b00);
        wd[0] = 32'h1;
        axi_wr(16'h0010, 1, 2'b01, 8'h0C, 2'b00);
        chk("irq_clr", 64'(irq), 0);
        rd1(16'h0010, 32'h0, 2'b00);

        // same-cycle DMADONE vs EN set and vs W1C
        wd[0] = 32'h1; done_mask = 2'b10;
        axi_wr(16'h0100, 1, 2'b01, 8'h0D, 2'b00);
        chk("done_beats_en", 64'(dmaen), 0);
        done_mask = 2'b01;
        axi_wr(16'h0010, 1, 2'b01, 8'h0E, 2'b00);
        done_mask = 2'b00;
        rd1(16'h0010, 32'h1, 2'b00);
        rd1(16'h0110, 32'h1, 2'b00);
        chk("irq_race", 64'(irq), 64'(IRQ_ON));

        // simultaneous AW/AR: write wins, read observes written value
        bq.push_back('{id: 8'h07, resp: 2'b00});
        exp_r(8'h08, 32'h55, 2'b00, 1'b1);
        bus.S_AWValid = 1; bus.S_AWAddr = 32'h0108; bus.S_AWLen = 0; bus.S_AWBurst = 1; bus.S_AWID = 8'h07;
        bus.S_ARValid = 1; bus.S_ARAddr = 32'h0108; bus.S_ARLen = 0; bus.S_ARBurst = 1; bus.S_ARID = 8'h08;
        @(negedge clk);
        chk("prio_ready", 64'({bus.S_AWReady, bus.S_ARReady}), 64'b10);
        @(posedge clk); #1;
        bus.S_AWValid = 0;
        bus.S_WValid = 1; bus.S_WData = 32'h55; bus.S_WStrb = 4'hF; bus.S_WLast = 1;
        @(negedge clk);
        chk("ar_held", 64'(bus.S_ARReady), 0);
        @(posedge clk); #1;
        bus.S_WValid = 0; bus.S_WLast = 0;
        wait_hs(2);
        wait_hs(3);
        bus.S_ARValid = 0;
        wait_hs(4);

        // reset in the middle of a write burst
        bus.S_AWValid = 1; bus.S_AWAddr = 32'h0104; bus.S_AWLen = 3; bus.S_AWBurst = 1; bus.S_AWID = 8'h44;
        wait_hs(0);
        bus.S_AWValid = 0;
        bus.S_WValid = 1; bus.S_WData = 32'h11; bus.S_WStrb = 4'hF; bus.S_WLast = 0;
        wait_hs(1);
        bus.S_WData = 32'h22;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_regs", {dmasrc, 14'h0, dmaen}, 0);
        chk("mid_rst_dst", dmadst, 0);
        chk("mid_rst_valid", 64'({bus.S_WReady, bus.S_BValid, bus.S_RValid, irq}), 0);
        chk("mid_rst_aw", 64'(bus.S_AWReady), 1);
        bus.S_WValid = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rd1(16'h0104, 32'h0, 2'b00);
        rd1(16'h0010, 32'h0, 2'b00);

        repeat (3) @(posedge clk);
        chk("bq_drained", 64'(bq.size()), 0);
        chk("rq_drained", 64'(rq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end
endmodule
